// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - ring packet encodings and ID sizing shared by both ring endpoints
package mem_pkg;

  localparam int ID_W    = 4;
  localparam int NUM_IDS = 1 << ID_W;
  localparam int ADDR_W  = 36;

  typedef enum logic [2:0] {
    PKT_EMPTY   = 3'b000,
    PKT_WR_REQ  = 3'b001,
    PKT_RD_REQ  = 3'b011,
    PKT_WR_ACK  = 3'b101,
    PKT_RD_DATA = 3'b110
  } pkt_type_e;

  function automatic logic is_rsp_type(input logic [2:0] t);
    return (t == PKT_WR_ACK) || (t == PKT_RD_DATA);
  endfunction

endpackage

// File: rtl/mem_req_port_if.sv
// rtl/mem_req_port_if.sv - cache-side request/response handshake bundle
interface mem_req_port_if import mem_pkg::*; #(parameter int DEPTH = 512);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DEPTH-1:0]  req_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [ID_W-1:0]   rsp_id;
  logic [DEPTH-1:0]  rsp_data;

  modport master (
    output req_valid, req_write, req_addr, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_write, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_write, rsp_id, rsp_data
  );

endinterface

// File: rtl/mem_id_alloc.sv
// rtl/mem_id_alloc.sv - transaction ID table: lowest-free allocation, release, busy count
module mem_id_alloc import mem_pkg::*; (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_alloc,
  input  logic               i_alloc_write,
  input  logic               i_free,
  input  logic [ID_W-1:0]    i_free_id,
  output logic               o_any_free,
  output logic [ID_W-1:0]    o_alloc_id,
  output logic [NUM_IDS-1:0] o_busy,
  output logic [NUM_IDS-1:0] o_wbit,
  output logic [ID_W:0]      o_count
);

  logic [NUM_IDS-1:0] r_busy;
  logic [NUM_IDS-1:0] r_wbit;

  // Scan from the top so the last hit is the lowest free index.
  always_comb begin
    o_any_free = 1'b0;
    o_alloc_id = '0;
    for (int i = NUM_IDS - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        o_any_free = 1'b1;
        o_alloc_id = ID_W'(i);
      end
    end
  end

  always_comb begin
    o_count = '0;
    for (int i = 0; i < NUM_IDS; i++) begin
      o_count = o_count + (ID_W + 1)'(r_busy[i]);
    end
  end

  // A freed ID is still busy this cycle, so it can never be reallocated in the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
      r_wbit <= '0;
    end else begin
      if (i_free) begin
        r_busy[i_free_id] <= 1'b0;
      end
      if (i_alloc) begin
        r_busy[o_alloc_id] <= 1'b1;
        r_wbit[o_alloc_id] <= i_alloc_write;
      end
    end
  end

  assign o_busy = r_busy;
  assign o_wbit = r_wbit;

endmodule

// File: rtl/mem_req_port.sv
// rtl/mem_req_port.sv - cache request port onto a slotted memory ring
// Optional MEM_REQ_PORT_STATS_EN adds rd_count/wr_count insertion counters.
module mem_req_port import mem_pkg::*; #(parameter int DEPTH = 512) (
  input  logic              clk,
  input  logic              rst,
  mem_req_port_if.slave     cache,
  input  logic [ID_W-1:0]   id_req_in,
  input  logic [2:0]        packet_type_req_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DEPTH-1:0]  data_in,
  output logic [ID_W-1:0]   id_req_out,
  output logic [2:0]        packet_type_req_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DEPTH-1:0]  data_out,
  output logic [ID_W:0]     outstanding,
  output logic              err
`ifdef MEM_REQ_PORT_STATS_EN
  ,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
`endif
);

  logic              r_ready_en;
  logic              r_hold_valid;
  logic              r_hold_write;
  logic [ID_W-1:0]   r_hold_id;
  logic [ADDR_W-1:0] r_hold_addr;
  logic [DEPTH-1:0]  r_hold_data;
  logic              r_rsp_valid;
  logic              r_rsp_write;
  logic [ID_W-1:0]   r_rsp_id;
  logic [DEPTH-1:0]  r_rsp_data;
  logic [2:0]        r_out_type;
  logic [ID_W-1:0]   r_out_id;
  logic [ADDR_W-1:0] r_out_addr;
  logic [DEPTH-1:0]  r_out_data;
  logic              r_err;

  logic               w_any_free;
  logic [ID_W-1:0]    w_alloc_id;
  logic [NUM_IDS-1:0] w_busy;
  logic [NUM_IDS-1:0] w_wbit;
  logic               w_req_fire;
  logic               w_rsp_fire;
  logic               w_is_rsp;
  logic               w_id_match;
  logic               w_consume;
  logic               w_slot_free;
  logic               w_insert;
  logic               w_bad_rsp;
  logic [2:0]         w_nxt_type;
  logic [ID_W-1:0]    w_nxt_id;
  logic [ADDR_W-1:0]  w_nxt_addr;
  logic [DEPTH-1:0]   w_nxt_data;

  mem_id_alloc u_id_alloc (
    .clk           (clk),
    .rst           (rst),
    .i_alloc       (w_req_fire),
    .i_alloc_write (cache.req_write),
    .i_free        (w_rsp_fire),
    .i_free_id     (r_rsp_id),
    .o_any_free    (w_any_free),
    .o_alloc_id    (w_alloc_id),
    .o_busy        (w_busy),
    .o_wbit        (w_wbit),
    .o_count       (outstanding)
  );

  assign cache.req_ready = r_ready_en & ~r_hold_valid & w_any_free;
  assign w_req_fire      = cache.req_valid & cache.req_ready;
  assign w_rsp_fire      = r_rsp_valid & cache.rsp_ready;

  // A busy ID with full, stalled response register is not an error: it comes round again.
  assign w_is_rsp    = is_rsp_type(packet_type_req_in);
  assign w_id_match  = w_busy[id_req_in] & (w_wbit[id_req_in] == (packet_type_req_in == PKT_WR_ACK));
  assign w_consume   = w_is_rsp & w_id_match & (~r_rsp_valid | cache.rsp_ready);
  assign w_bad_rsp   = w_is_rsp & ~w_id_match;
  assign w_slot_free = (packet_type_req_in == PKT_EMPTY) | w_consume;
  assign w_insert    = w_slot_free & r_hold_valid;

  always_comb begin
    w_nxt_type = packet_type_req_in;
    w_nxt_id   = id_req_in;
    w_nxt_addr = addr_in;
    w_nxt_data = data_in;
    if (w_insert) begin
      w_nxt_type = r_hold_write ? PKT_WR_REQ : PKT_RD_REQ;
      w_nxt_id   = r_hold_id;
      w_nxt_addr = r_hold_addr;
      w_nxt_data = r_hold_data;
    end else if (w_slot_free) begin
      w_nxt_type = PKT_EMPTY;
      w_nxt_id   = '0;
      w_nxt_addr = '0;
      w_nxt_data = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ready_en   <= 1'b0;
      r_hold_valid <= 1'b0;
      r_hold_write <= 1'b0;
      r_hold_id    <= '0;
      r_hold_addr  <= '0;
      r_hold_data  <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_write  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_data   <= '0;
      r_out_type   <= PKT_EMPTY;
      r_out_id     <= '0;
      r_out_addr   <= '0;
      r_out_data   <= '0;
      r_err        <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_req_fire) begin
        r_hold_valid <= 1'b1;
        r_hold_write <= cache.req_write;
        r_hold_id    <= w_alloc_id;
        r_hold_addr  <= cache.req_addr;
        r_hold_data  <= cache.req_data;
      end else if (w_insert) begin
        r_hold_valid <= 1'b0;
      end
      if (w_consume) begin
        r_rsp_valid <= 1'b1;
        r_rsp_write <= (packet_type_req_in == PKT_WR_ACK);
        r_rsp_id    <= id_req_in;
        r_rsp_data  <= data_in;
      end else if (w_rsp_fire) begin
        r_rsp_valid <= 1'b0;
      end
      r_out_type <= w_nxt_type;
      r_out_id   <= w_nxt_id;
      r_out_addr <= w_nxt_addr;
      r_out_data <= w_nxt_data;
      if (w_bad_rsp) begin
        r_err <= 1'b1;
      end
    end
  end

  assign cache.rsp_valid   = r_rsp_valid;
  assign cache.rsp_write   = r_rsp_write;
  assign cache.rsp_id      = r_rsp_id;
  assign cache.rsp_data    = r_rsp_data;
  assign packet_type_req_out = r_out_type;
  assign id_req_out        = r_out_id;
  assign addr_out          = r_out_addr;
  assign data_out          = r_out_data;
  assign err               = r_err;

`ifdef MEM_REQ_PORT_STATS_EN
  logic [31:0] r_rd_count;
  logic [31:0] r_wr_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else if (w_insert) begin
      if (r_hold_write) begin
        r_wr_count <= r_wr_count + 32'd1;
      end else begin
        r_rd_count <= r_rd_count + 32'd1;
      end
    end
  end

  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;
`endif

endmodule

// File: doc/mem_req_port.md
MEM_REQ_PORT -- requirements
Module: mem_req_port

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (input, 1, rising-edge clock) and rst (input, 1, asynchronous active-low reset).
REQ-002 The block SHALL have parameter DEPTH, default 512, giving the data_in, data_out and req_data width; only 512 is supported.
REQ-003 The cache-side request ports SHALL be:
- req_valid (input, 1): request offered.
- req_ready (output, 1): request accepted this cycle.
- req_write (input, 1): 1 = write, 0 = read.
- req_addr (input, 36): line address.
- req_data (input, DEPTH): write data.
REQ-004 The cache-side response ports SHALL be:
- rsp_valid (output, 1): response presented.
- rsp_ready (input, 1): response taken.
- rsp_write (output, 1): response is a write ack.
- rsp_id (output, 4): transaction ID.
- rsp_data (output, DEPTH): read data.
REQ-005 The ring-input ports SHALL be id_req_in (input, 4), packet_type_req_in (input, 3), addr_in (input, 36) and data_in (input, DEPTH).
REQ-006 The ring-output ports SHALL be id_req_out (output, 4), packet_type_req_out (output, 3), addr_out (output, 36) and data_out (output, DEPTH).
REQ-007 The status ports SHALL be outstanding (output, 5), the count of IDs in flight, and err (output, 1), a sticky flag for an unmatched response.

Function
REQ-008 Packet type encodings SHALL be: 000 empty, 001 write request, 011 read request, 101 write ack, 110 read data.
REQ-009 The block SHALL keep a 16-entry ID table with one busy bit and one write bit per ID.
REQ-010 The request path SHALL behave as follows:
- req_ready = holding register empty AND at least one free ID.
- A handshake captures the request into the holding register.
- The lowest-index free ID is allocated and marked busy in the same cycle.
REQ-011 Each cycle, the incoming ring slot SHALL be classified as:
- consumable: type is 101 or 110, id_req_in is busy, the type matches the ID's write bit, and the response register is empty or being drained (rsp_ready and rsp_valid).
- free: type is 000, or the slot is consumable.
REQ-012 A consumed slot SHALL load the response register: rsp_data = data_in, rsp_write = (type == 101), rsp_id = id_req_in.
- The ID is freed when the rsp_valid/rsp_ready handshake completes, not when the slot is consumed.
REQ-013 If the slot is free and the holding register is full, the block SHALL drive the held request onto the next-cycle ring output (type 001 or 011, its ID, address and data) and empty the holding register.
REQ-014 Otherwise the block SHALL forward the incoming packet unchanged.
- A free slot with no pending request is output as type 000 with all other fields zero.
REQ-015 All ring outputs SHALL be registered, so ring-in to ring-out latency is exactly 1 cycle.
REQ-016 Unconsumable response cases SHALL be handled as follows:
- Busy ID but the response register is full and not draining: forward unchanged; this is retried on the next ring lap, and err is not set.
- ID not busy, or type mismatch: forward unchanged and set err.
REQ-017 Simultaneous events SHALL resolve as follows:
- A single slot both consumes a response and inserts a request; the same ID is never freed and reallocated in the same cycle.
- An ID freed by a rsp handshake is allocatable from the next cycle.
REQ-018 outstanding SHALL equal the busy-bit population count, range 0..16.
- At 16, req_ready = 0.
- The holding register empties when the request is inserted onto the ring.

Reset
REQ-019 While rst is low, the block SHALL clear every table entry and register.
- Outputs: req_ready = 0, rsp_valid = 0, packet_type_req_out = 000, all data, address and ID outputs = 0, outstanding = 0, err = 0.
- req_ready rises on the first clk edge after rst deasserts.
- Reset mid-transaction discards all in-flight state; later responses for discarded IDs set err.

Configuration
REQ-020 When macro MEM_REQ_PORT_STATS_EN is defined, the block SHALL add outputs rd_count and wr_count (32 bits each, wrapping, reset 0).
- They increment once per inserted read request and write request respectively.
- When the macro is undefined, these ports and counters are absent.

Structure
REQ-021 Packet type encodings and the ID width (4) SHALL reside in shared package mem_pkg, used by both ring endpoints.
REQ-022 ID allocation (priority encoder over busy bits, free/alloc update, popcount) SHALL be sub-module mem_id_alloc.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Read at 0x000001000 with idle ring (type 000): ring out is type 011, id 0, addr 0x000001000 one cycle later; returning 110/id 0/data 0xA5.. gives rsp_valid with rsp_data 0xA5.. and rsp_write 0.
- 16 reads with no responses: outstanding = 16 and req_ready = 0; one 110 response plus rsp handshake gives req_ready = 1 the next cycle and ID reuse.
- rsp_ready held 0 with two busy-ID responses arriving: the first is captured, the second is forwarded unchanged, and err stays 0.
- Response 101 for non-busy id 7: forwarded unchanged, err = 1 and sticky.
- A foreign type 001 packet in the slot while a request is held: the packet is forwarded and insertion waits for the next free slot.
- rst asserted with 3 IDs outstanding: all outputs are at reset values; after release, outstanding = 0.
